wb_trace_checker: RTL and testbench
===================================

# wb_trace_checker

Writeback-trace checker that sits directly downstream of `testcpu`'s debug writeback port. It captures every committed register write (`debug_wb_*`) into a small FIFO and compares each one, in order, against a golden trace stream supplied through a valid/ready handshake. It reports the first mismatch, overflow, commit count and end-of-test. It is synthesizable so it can run both in the simulation bench and on FPGA alongside the CPU.

## Interface
- `FIFO_DEPTH`, 8: capture FIFO entries; must be a power of two, ≥2.
- `END_PC`, 32'hBFC0_0100: writeback PC that marks test completion.
- `CNT_W`, 32: width of the commit counter.

- `clk` input 1: single clock; all state on the rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `debug_wb_pc` input 32: PC of the instruction in writeback.
- `debug_wb_rf_wen` input 4: byte write enables; 4'h0 means no write.
- `debug_wb_rf_wnum` input 5: destination register.
- `debug_wb_rf_wdata` input 32: write data.
- `gold_valid` input 1: golden entry available.
- `gold_ready` output 1: checker consumes the golden entry this cycle.
- `gold_pc` input 32: expected PC.
- `gold_wnum` input 5: expected register.
- `gold_wdata` input 32: expected data.
- `commit_cnt` output CNT_W: number of compared entries that matched.
- `mismatch` output 1: sticky; first compare failed.
- `overflow` output 1: sticky; a capture was dropped because the FIFO was full.
- `done` output 1: sticky; END_PC seen and FIFO drained without error.
- `err_pc` output 32: captured PC of the first failing entry.
- `err_exp` output 32: golden data of the first failing entry.
- `err_got` output 32: masked DUT data of the first failing entry.

## Operation
- **Capture.** A cycle is captured when `debug_wb_rf_wen != 0` and `debug_wb_rf_wnum != 0`, in states RUN and DRAIN only. Each entry stores {pc, wen, wnum, wdata}.
- **Compare.** A compare fires when the FIFO is non-empty, `gold_valid` is high and the state is RUN or DRAIN.
  - `gold_ready` is asserted for that one cycle.
  - The FIFO head is popped in the same cycle.
- **Match rule.** All three must hold:
  - pc equal;
  - wnum equal;
  - for each byte i with wen[i]=1, wdata byte equals gold_wdata byte. Bytes with wen[i]=0 are ignored.
  - `err_got` and `err_exp` report the data with those disabled bytes zeroed.
- **State machine** (enum in package):
  - RUN → DRAIN when the `debug_wb_pc == END_PC` cycle arrives. Any register write made in that cycle is captured too.
  - RUN/DRAIN → ERROR on a failed compare or on overflow.
  - DRAIN → DONE when the FIFO is empty and no compare is in flight.
  - ERROR and DONE are terminal until reset. In both, captures and compares stop and `gold_ready` stays 0.
- **Sticky outputs.** `mismatch`, `overflow` and `done` are sticky. The `err_*` registers load only on the first failure.
- **Counter.** `commit_cnt` increments on each matching compare and saturates at all-ones.

## Timing
- Reset values: all outputs 0, state RUN, FIFO empty.
- Reset asserted mid-operation clears everything immediately, with no drain.
- Capture latency: an entry written at edge N is comparable in cycle N+1. Fall-through is not allowed.
- Compare result is registered: `mismatch`, `err_*` and `commit_cnt` update at the edge that ends the compare cycle.
- Throughput is one compare per cycle.
- Push and pop in the same cycle when full: legal; no overflow, and occupancy is unchanged.
- Push while full without a pop: the entry is dropped and `overflow` is set at the next edge.
- If the mismatch and overflow conditions occur in the same cycle, both flags set and state goes to ERROR.
- `gold_ready` is combinational from the FIFO-empty flag, the state and `gold_valid`. `gold_valid` may not depend on `gold_ready`.
- `done` rises one cycle after the FIFO becomes empty in DRAIN.

## Structure
- Package `cpu_trace_pkg` holds:
  - `trace_entry_t` struct {pc[31:0], wen[3:0], wnum[4:0], wdata[31:0]};
  - `chk_state_t` enum {RUN, DRAIN, ERROR, DONE};
  - a byte-mask expansion function (4→32 bits).
- One sub-module, `trace_fifo`: a synchronous FIFO of `trace_entry_t` with `push`, `pop`, `full`, `empty`, parameterized depth, wrap-around pointers plus one extra bit for full/empty. The checker FSM, compare and counters stay in the top.

## Test plan
- **Matching trace.** 5 writes to r1..r5 with data 0x11..0x55 and identical golden entries, then END_PC → `commit_cnt`=5, `done`=1, `mismatch`=0.
- **Byte-masked compare.**
  - wen=4'b0011, wdata=0xDEAD_BEEF, gold_wdata=0x0000_BEEF → match.
  - gold_wdata=0x0000_BEEE → `mismatch`=1, `err_got`=0x0000_BEEF, `err_exp`=0x0000_BEEE.
- **Filtering.** Writes with wnum=0 or wen=0 are not captured; `commit_cnt` is unchanged and no gold entry is consumed.
- **Overflow.**
  - `gold_valid` held 0 while 9 writes arrive with FIFO_DEPTH=8 → `overflow`=1 on the 9th; state ERROR; `gold_ready` stays 0.
  - Repeat with one pop in the 9th cycle → no overflow.
- **PC mismatch.** Second entry has pc 0xBFC0_0008 against gold 0xBFC0_000C → `mismatch`=1, `err_pc`=0xBFC0_0008, `commit_cnt`=1; later entries are ignored.
- **Reset mid-DRAIN.** Deassert `resetn` with 3 entries queued → all outputs 0 and FIFO empty immediately. After release, a fresh matching trace completes with `done`=1.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// Shared types for the writeback-trace checker.
//   trace_entry_t : one captured writeback {pc, wen, wnum, wdata}
//   chk_state_t   : checker FSM states
//   byte_mask()   : expands 4 byte enables into a 32-bit data mask
package cpu_trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } trace_entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ERROR = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  function automatic logic [31:0] byte_mask(input logic [3:0] wen);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{wen[i]}};
    return m;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace_entry_t.
//   clk, resetn : clock, async active-low reset (pointers only)
//   push, din   : write an entry (caller guarantees !full || pop)
//   pop, dout   : dout is the head, valid while !empty; pop advances it
//   full, empty : occupancy flags from the extra pointer wrap bit
// No fall-through: a pushed entry is visible at dout only after the edge.
module trace_fifo
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  trace_entry_t din,
  input  logic         pop,
  output trace_entry_t dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  trace_entry_t  mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/wb_trace_checker.sv
// Writeback-trace checker. Captures committed register writes from the CPU
// debug port into a FIFO and compares them in order against a golden stream.
//   clk, resetn        : clock, async active-low reset
//   debug_wb_*         : CPU writeback port (captured when wen!=0, wnum!=0)
//   gold_valid/ready   : golden entry handshake; ready is combinational
//   gold_pc/wnum/wdata : expected writeback
//   commit_cnt         : matching compares, saturating
//   mismatch/overflow  : sticky error flags
//   done               : END_PC seen and FIFO drained cleanly
//   err_pc/exp/got     : first failing entry (data masked by wen)
module wb_trace_checker
  import cpu_trace_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] END_PC     = 32'hBFC0_0100,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      debug_wb_pc,
  input  logic [3:0]       debug_wb_rf_wen,
  input  logic [4:0]       debug_wb_rf_wnum,
  input  logic [31:0]      debug_wb_rf_wdata,
  input  logic             gold_valid,
  output logic             gold_ready,
  input  logic [31:0]      gold_pc,
  input  logic [4:0]       gold_wnum,
  input  logic [31:0]      gold_wdata,
  output logic [CNT_W-1:0] commit_cnt,
  output logic             mismatch,
  output logic             overflow,
  output logic             done,
  output logic [31:0]      err_pc,
  output logic [31:0]      err_exp,
  output logic [31:0]      err_got
);

  chk_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mismatch_q, mismatch_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;
  logic [31:0]      err_pc_q, err_pc_d;
  logic [31:0]      err_exp_q, err_exp_d;
  logic [31:0]      err_got_q, err_got_d;

  trace_entry_t wr_ent, head;
  logic         fifo_full, fifo_empty;
  logic         active, capture, compare, push, ovf_evt, mis_evt;
  logic [31:0]  mask, got_m, exp_m;

  assign active  = (state_q == RUN) || (state_q == DRAIN);
  assign capture = active && (debug_wb_rf_wen != 4'h0) && (debug_wb_rf_wnum != 5'd0);
  assign compare = active && !fifo_empty && gold_valid;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push    = capture && (!fifo_full || compare);
  assign ovf_evt = capture && fifo_full && !compare;

  assign wr_ent = '{pc: debug_wb_pc, wen: debug_wb_rf_wen,
                    wnum: debug_wb_rf_wnum, wdata: debug_wb_rf_wdata};

  trace_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (wr_ent),
    .pop    (compare),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign mask    = byte_mask(head.wen);
  assign got_m   = head.wdata & mask;
  assign exp_m   = gold_wdata & mask;
  assign mis_evt = compare &&
                   ((head.pc != gold_pc) || (head.wnum != gold_wnum) || (got_m != exp_m));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mismatch_d = mismatch_q;
    overflow_d = overflow_q;
    done_d     = done_q;
    err_pc_d   = err_pc_q;
    err_exp_d  = err_exp_q;
    err_got_d  = err_got_q;

    if (compare && !mis_evt && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;

    // err_* load only once: mismatch can only fire while still active,
    // and the first failure leaves the active states for good.
    if (mis_evt) begin
      mismatch_d = 1'b1;
      err_pc_d   = head.pc;
      err_exp_d  = exp_m;
      err_got_d  = got_m;
    end
    if (ovf_evt) overflow_d = 1'b1;

    unique case (state_q)
      RUN: begin
        if (mis_evt || ovf_evt)       state_d = ERROR;
        else if (debug_wb_pc == END_PC) state_d = DRAIN;
      end
      DRAIN: begin
        if (mis_evt || ovf_evt) state_d = ERROR;
        else if (fifo_empty && !push) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      mismatch_q <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      err_pc_q   <= '0;
      err_exp_q  <= '0;
      err_got_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mismatch_q <= mismatch_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      err_pc_q   <= err_pc_d;
      err_exp_q  <= err_exp_d;
      err_got_q  <= err_got_d;
    end
  end

  assign gold_ready = compare;
  assign commit_cnt = cnt_q;
  assign mismatch   = mismatch_q;
  assign overflow   = overflow_q;
  assign done       = done_q;
  assign err_pc     = err_pc_q;
  assign err_exp    = err_exp_q;
  assign err_got    = err_got_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker. Inputs change on the falling edge;
// gold_ready is sampled just before the rising edge and the golden queue
// pops when the checker took the entry.
module tb_wb_trace_checker;

  localparam logic [31:0] END_PC = 32'hBFC0_0100;
  localparam logic [31:0] PC0    = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        gold_valid;
  logic        gold_ready;
  logic [31:0] gold_pc;
  logic [4:0]  gold_wnum;
  logic [31:0] gold_wdata;
  logic [31:0] commit_cnt;
  logic        mismatch, overflow, done;
  logic [31:0] err_pc, err_exp, err_got;

  always #5 clk = ~clk;

  wb_trace_checker #(.FIFO_DEPTH(8), .END_PC(END_PC), .CNT_W(32)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .gold_valid        (gold_valid),
    .gold_ready        (gold_ready),
    .gold_pc           (gold_pc),
    .gold_wnum         (gold_wnum),
    .gold_wdata        (gold_wdata),
    .commit_cnt        (commit_cnt),
    .mismatch          (mismatch),
    .overflow          (overflow),
    .done              (done),
    .err_pc            (err_pc),
    .err_exp           (err_exp),
    .err_got           (err_got)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } gold_t;

  gold_t gq[$];
  logic  gold_en;
  logic  last_rdy;
  int    n_chk  = 0;
  int    n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
  endtask

  task automatic gpush(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
    gold_t g;
    g.pc = pc; g.wnum = wn; g.wdata = wd;
    gq.push_back(g);
  endtask

  // One clock cycle with the given writeback on the debug port.
  task automatic cyc(input logic [31:0] pc, input logic [3:0] wen,
                     input logic [4:0] wn, input logic [31:0] wd);
    debug_wb_pc       = pc;
    debug_wb_rf_wen   = wen;
    debug_wb_rf_wnum  = wn;
    debug_wb_rf_wdata = wd;
    if (gold_en && gq.size() > 0) begin
      gold_valid = 1'b1;
      gold_pc    = gq[0].pc;
      gold_wnum  = gq[0].wnum;
      gold_wdata = gq[0].wdata;
    end else begin
      gold_valid = 1'b0;
      gold_pc    = '0;
      gold_wnum  = '0;
      gold_wdata = '0;
    end
    #1 last_rdy = gold_ready;
    @(posedge clk);
    if (last_rdy && gq.size() > 0) void'(gq.pop_front());
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(32'h0, 4'h0, 5'd0, 32'h0);
  endtask

  task automatic do_reset();
    gq.delete();
    gold_en = 1'b0;
    resetn  = 1'b0;
    idle(2);
    resetn  = 1'b1;
    idle(1);
  endtask

  initial begin
    resetn = 1'b0;
    gold_en = 1'b0;
    @(negedge clk);
    do_reset();

    // reset state
    chk("rst_cnt", commit_cnt, 32'd0);
    chk("rst_flags", {29'd0, mismatch, overflow, done}, 32'd0);
    chk("rst_err_pc", err_pc, 32'd0);
    chk("rst_err_exp", err_exp, 32'd0);
    chk("rst_err_got", err_got, 32'd0);

    // matching trace r1..r5, data 0x11..0x55
    for (int i = 1; i <= 5; i++) gpush(PC0 + 32'(4*i), 5'(i), 32'(i * 'h11));
    gold_en = 1'b1;
    cyc(PC0 + 32'd4, 4'hF, 5'd1, 32'h11);
    chk("no_fallthru", {31'd0, last_rdy}, 32'd0);
    cyc(PC0 + 32'd8, 4'hF, 5'd2, 32'h22);
    chk("first_cmp_rdy", {31'd0, last_rdy}, 32'd1);
    for (int i = 3; i <= 5; i++) cyc(PC0 + 32'(4*i), 4'hF, 5'(i), 32'(i * 'h11));
    cyc(END_PC, 4'h0, 5'd0, 32'h0);
    chk("match_done_early", {31'd0, done}, 32'd0);
    idle(1);
    chk("match_done", {31'd0, done}, 32'd1);
    chk("match_cnt", commit_cnt, 32'd5);
    chk("match_mis", {31'd0, mismatch}, 32'd0);
    chk("match_gold_used", gq.size(), 32'd0);

    // byte-masked compare
    do_reset();
    gold_en = 1'b1;
    gpush(PC0, 5'd7, 32'h0000_BEEF);
    cyc(PC0, 4'b0011, 5'd7, 32'hDEAD_BEEF);
    idle(2);
    chk("mask_match_cnt", commit_cnt, 32'd1);
    chk("mask_match_mis", {31'd0, mismatch}, 32'd0);
    gpush(PC0 + 32'd4, 5'd7, 32'h0000_BEEE);
    cyc(PC0 + 32'd4, 4'b0011, 5'd7, 32'hDEAD_BEEF);
    idle(2);
    chk("mask_mis", {31'd0, mismatch}, 32'd1);
    chk("mask_err_got", err_got, 32'h0000_BEEF);
    chk("mask_err_exp", err_exp, 32'h0000_BEEE);
    chk("mask_cnt_hold", commit_cnt, 32'd1);

    // filtering of wnum=0 and wen=0
    do_reset();
    gold_en = 1'b1;
    gpush(PC0, 5'd2, 32'h7);
    cyc(PC0, 4'hF, 5'd0, 32'h7);
    cyc(PC0, 4'h0, 5'd2, 32'h7);
    idle(2);
    chk("filt_gold_kept", gq.size(), 32'd1);
    chk("filt_cnt", commit_cnt, 32'd0);
    cyc(PC0, 4'hF, 5'd2, 32'h7);
    idle(1);
    chk("filt_real_cnt", commit_cnt, 32'd1);

    // overflow: 9 writes, no gold
    do_reset();
    for (int i = 1; i <= 8; i++) cyc(PC0 + 32'(4*i), 4'hF, 5'(i), 32'(i));
    chk("ovf_8_ok", {31'd0, overflow}, 32'd0);
    cyc(PC0 + 32'd36, 4'hF, 5'd9, 32'd9);
    chk("ovf_9", {31'd0, overflow}, 32'd1);
    gpush(PC0 + 32'd4, 5'd1, 32'd1);
    gold_en = 1'b1;
    idle(1);
    chk("ovf_rdy_low", {31'd0, last_rdy}, 32'd0);
    cyc(END_PC, 4'h0, 5'd0, 32'h0);
    idle(2);
    chk("ovf_no_done", {31'd0, done}, 32'd0);
    chk("ovf_cnt", commit_cnt, 32'd0);

    // full + simultaneous pop on 9th write
    do_reset();
    for (int i = 1; i <= 8; i++) cyc(PC0 + 32'(4*i), 4'hF, 5'(i), 32'(i));
    gpush(PC0 + 32'd4, 5'd1, 32'd1);
    gold_en = 1'b1;
    cyc(PC0 + 32'd36, 4'hF, 5'd9, 32'd9);
    idle(2);
    chk("pushpop_ovf", {31'd0, overflow}, 32'd0);
    chk("pushpop_cnt", commit_cnt, 32'd1);
    // remaining 8 entries (2..9) should all still match in order
    for (int i = 2; i <= 9; i++) gpush(PC0 + 32'(4*i), 5'(i), 32'(i));
    idle(10);
    chk("pushpop_rest", commit_cnt, 32'd9);

    // PC mismatch on second entry
    do_reset();
    gold_en = 1'b1;
    gpush(PC0, 5'd1, 32'd1);
    gpush(PC0 + 32'hC, 5'd2, 32'd2);
    gpush(PC0 + 32'h10, 5'd3, 32'd3);
    cyc(PC0, 4'hF, 5'd1, 32'd1);
    cyc(PC0 + 32'h8, 4'hF, 5'd2, 32'd2);
    cyc(PC0 + 32'h10, 4'hF, 5'd3, 32'd3);
    idle(3);
    chk("pc_mis", {31'd0, mismatch}, 32'd1);
    chk("pc_err_pc", err_pc, 32'hBFC0_0008);
    chk("pc_cnt", commit_cnt, 32'd1);
    chk("pc_later_ignored", gq.size(), 32'd1);

    // reset mid-DRAIN with 3 entries queued
    do_reset();
    for (int i = 1; i <= 3; i++) cyc(PC0 + 32'(4*i), 4'hF, 5'(i), 32'(i));
    cyc(END_PC, 4'h0, 5'd0, 32'h0);
    gold_en = 1'b1;
    gpush(PC0 + 32'd4, 5'd1, 32'd1);
    resetn = 1'b0;
    #1;
    chk("rstd_ready", {31'd0, gold_ready}, 32'd0);
    chk("rstd_flags", {29'd0, mismatch, overflow, done}, 32'd0);
    chk("rstd_cnt", commit_cnt, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    idle(1);
    chk("rstd_empty", {31'd0, last_rdy}, 32'd0);
    gq.delete();
    for (int i = 1; i <= 3; i++) gpush(PC0 + 32'(4*i), 5'(i), 32'(i * 3));
    for (int i = 1; i <= 3; i++) cyc(PC0 + 32'(4*i), 4'hF, 5'(i), 32'(i * 3));
    cyc(END_PC, 4'h0, 5'd0, 32'h0);
    idle(2);
    chk("rstd_fresh_done", {31'd0, done}, 32'd1);
    chk("rstd_fresh_cnt", commit_cnt, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
